// File: rtl/line_ram_pkg.sv
// Shared definitions for the line RAM arbiter: FSM state encoding and default bus widths.
package line_ram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

endpackage

// File: rtl/line_ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM pins owned by the line RAM arbiter.
interface line_ram_arbiter_if
  import line_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_write;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_write, ram_data_in
  );

  // Line engines plus RAM side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_write, ram_data_in
  );

endinterface

// File: rtl/line_ram_hold_timer.sv
// Counts granted access cycles of the current owner; expired flags the last allowed cycle.
module line_ram_hold_timer #(
  parameter int MAX_HOLD = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LAST so preemption fires as soon as the other side asks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/line_ram_arbiter.sv
// Burst-granting round-robin arbiter sharing the 256x8 line RAM between RX writer and TX reader.
// Optional forced release after MAX_HOLD granted cycles: define LINE_RAM_ARB_TIMEOUT_EN.
module line_ram_arbiter
  import line_ram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = 64
) (
  input logic               clock,
  input logic               reset,
  line_ram_arbiter_if.slave bus
);

  state_t            state, state_nxt;
  logic              last_owner, last_owner_nxt;
  logic              gnt0, gnt1;
  logic              rvalid0_q, rvalid1_q;
  logic              hold_expired;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              write_mux;

  if (MAX_HOLD < 2) begin : g_max_hold_check
    $error("line_ram_arbiter: MAX_HOLD must be at least 2");
  end

  assign gnt0 = (state == ST_OWN0);
  assign gnt1 = (state == ST_OWN1);

`ifdef LINE_RAM_ARB_TIMEOUT_EN
  logic hold_en;
  logic hold_clear;

  assign hold_en    = (gnt0 & bus.req0) | (gnt1 & bus.req1);
  assign hold_clear = (state == ST_IDLE) || (state_nxt != state);

  line_ram_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clock    (clock),
    .reset    (reset),
    .count_en (hold_en),
    .clear    (hold_clear),
    .expired  (hold_expired)
  );
`else
  assign hold_expired = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    unique case (state)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) state_nxt = last_owner ? ST_OWN0 : ST_OWN1;
        else if (bus.req0)        state_nxt = ST_OWN0;
        else if (bus.req1)        state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!bus.req0) begin
          last_owner_nxt = 1'b0;
          state_nxt      = bus.req1 ? ST_OWN1 : ST_IDLE;
        end else if (hold_expired && bus.req1) begin
          last_owner_nxt = 1'b0;
          state_nxt      = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!bus.req1) begin
          last_owner_nxt = 1'b1;
          state_nxt      = bus.req0 ? ST_OWN0 : ST_IDLE;
        end else if (hold_expired && bus.req0) begin
          last_owner_nxt = 1'b1;
          state_nxt      = ST_OWN0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RAM pins follow the owner; a dropped req is a release, so it never writes.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    write_mux = 1'b0;
    unique case (state)
      ST_OWN0: begin
        addr_mux  = bus.addr0;
        wdata_mux = bus.wdata0;
        write_mux = bus.req0 & bus.we0;
      end
      ST_OWN1: begin
        addr_mux  = bus.addr1;
        wdata_mux = bus.wdata1;
        write_mux = bus.req1 & bus.we1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      rvalid0_q  <= gnt0 & bus.req0 & ~bus.we0;
      rvalid1_q  <= gnt1 & bus.req1 & ~bus.we1;
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rdata       = bus.ram_data_out;
  assign bus.ram_addr    = addr_mux;
  assign bus.ram_data_in = wdata_mux;
  assign bus.ram_write   = write_mux;

endmodule

// File: tb/tb_line_ram_arbiter.sv
// Directed bench for line_ram_arbiter with a 256x8 registered-address RAM model attached.
module tb_line_ram_arbiter;
  import line_ram_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] line_vals [5] = '{8'h41, 8'h44, 8'h41, 8'h4D, 8'h00};

  line_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  line_ram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Single-port RAM: address registered on the edge, data out one cycle later.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] raddr_q = 8'h00;

  always @(posedge clock) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_data_in;
    raddr_q <= bus.ram_addr;
  end

  assign bus.ram_data_out = mem[raddr_q];

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    idle_inputs();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt/rvalid/write=%b expected 00000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_write});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_data_in} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ram_pins: got addr=%h din=%h expected 00 00", bus.ram_addr, bus.ram_data_in);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got gnt=%b expected 00", {bus.gnt0, bus.gnt1});
    end
  endtask

  task automatic test_single_writer;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h01; bus.wdata0 = line_vals[0];
    #1;
    checks++;
    if ({bus.gnt0, bus.ram_write} !== 2'b00) begin
      errors++;
      $display("FAIL writer_idle_no_write: got gnt0/write=%b expected 00", {bus.gnt0, bus.ram_write});
    end
    step();
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL writer_grant: got gnt0=%b expected 1", bus.gnt0);
    end
    for (int i = 0; i < 5; i++) begin
      bus.addr0  = 8'(i + 1);
      bus.wdata0 = line_vals[i];
      #1;
      checks++;
      if ({bus.ram_write, bus.ram_addr, bus.ram_data_in} !== {1'b1, 8'(i + 1), line_vals[i]}) begin
        errors++;
        $display("FAIL writer_pins_%0d: got write=%b addr=%h din=%h expected 1 %h %h",
                 i, bus.ram_write, bus.ram_addr, bus.ram_data_in, 8'(i + 1), line_vals[i]);
      end
      step();
    end
    bus.req0 = 1'b0;
    #1;
    checks++;
    if (bus.ram_write !== 1'b0) begin
      errors++;
      $display("FAIL writer_release_no_write: got write=%b expected 0", bus.ram_write);
    end
    step();
    checks++;
    if ({bus.gnt0, bus.ram_write} !== 2'b00) begin
      errors++;
      $display("FAIL writer_back_idle: got gnt0/write=%b expected 00", {bus.gnt0, bus.ram_write});
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem[i + 1] !== line_vals[i]) begin
        errors++;
        $display("FAIL writer_mem_%0d: got %h expected %h", i + 1, mem[i + 1], line_vals[i]);
      end
    end
  endtask

  task automatic test_readback;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h01;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL read_grant: got gnt=%b expected 01", {bus.gnt0, bus.gnt1});
    end
    for (int i = 0; i < 5; i++) begin
      bus.addr1 = 8'(i + 1);
      step();
      checks++;
      if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b10, line_vals[i]}) begin
        errors++;
        $display("FAIL read_data_%0d: got rvalid1=%b rvalid0=%b rdata=%h expected 1 0 %h",
                 i, bus.rvalid1, bus.rvalid0, bus.rdata, line_vals[i]);
      end
    end
    bus.req1 = 1'b0;
    step();
    checks++;
    if ({bus.gnt1, bus.rvalid1} !== 2'b00) begin
      errors++;
      $display("FAIL read_release: got gnt1/rvalid1=%b expected 00", {bus.gnt1, bus.rvalid1});
    end
  endtask

  task automatic test_back_to_back;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h5A;
    step();
    step();
    checks++;
    if (bus.rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_write_no_rvalid: got rvalid0=%b expected 0", bus.rvalid0);
    end
    bus.we0 = 1'b0;
    step();
    checks++;
    if ({bus.rvalid0, bus.rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL b2b_read_new_data: got rvalid0=%b rdata=%h expected 1 5a", bus.rvalid0, bus.rdata);
    end
    bus.req0 = 1'b0;
    step();
  endtask

  task automatic test_release_after_read;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
    step();
    step();
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h04;
    #1;
    checks++;
    if ({bus.rvalid1, bus.rdata, bus.ram_write} !== {1'b1, 8'h44, 1'b0}) begin
      errors++;
      $display("FAIL release_read_data: got rvalid1=%b rdata=%h write=%b expected 1 44 0",
               bus.rvalid1, bus.rdata, bus.ram_write);
    end
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL release_handover: got gnt=%b expected 10", {bus.gnt0, bus.gnt1});
    end
    step();
    checks++;
    if ({bus.rvalid0, bus.rdata} !== {1'b1, 8'h4D}) begin
      errors++;
      $display("FAIL release_next_read: got rvalid0=%b rdata=%h expected 1 4d", bus.rvalid0, bus.rdata);
    end
    bus.req0 = 1'b0;
    step();
  endtask

  task automatic test_tie;
    apply_reset();
    bus.req0 = 1'b1; bus.addr0 = 8'h03;
    bus.req1 = 1'b1; bus.addr1 = 8'h04;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL tie_first: got gnt=%b expected 10", {bus.gnt0, bus.gnt1});
    end
    step();
    bus.req0 = 1'b0;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL tie_handover: got gnt=%b expected 01", {bus.gnt0, bus.gnt1});
    end
    bus.req1 = 1'b0;
    step();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL tie_after_owner1: got gnt=%b expected 10", {bus.gnt0, bus.gnt1});
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL tie_after_owner0: got gnt=%b expected 01", {bus.gnt0, bus.gnt1});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_burst;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
    step();
    step();
    bus.we0 = 1'b1; bus.addr0 = 8'h09; bus.wdata0 = 8'hAA;
    #1;
    checks++;
    if ({bus.gnt0, bus.rvalid0, bus.ram_write} !== 3'b111) begin
      errors++;
      $display("FAIL midburst_setup: got gnt0/rvalid0/write=%b expected 111",
               {bus.gnt0, bus.rvalid0, bus.ram_write});
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_write, bus.ram_addr} !== 13'b0) begin
      errors++;
      $display("FAIL midburst_async_clear: got gnt/rvalid/write=%b addr=%h expected 00000 00",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_write}, bus.ram_addr);
    end
    step();
    bus.req0 = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1, mem[9]} !== 10'b0) begin
      errors++;
      $display("FAIL midburst_after_release: got gnt=%b mem9=%h expected 00 00",
               {bus.gnt0, bus.gnt1}, mem[9]);
    end
  endtask

  task automatic test_timeout;
    int held;
    apply_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 8'h11;
    step();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h01;
    held = 0;
`ifdef LINE_RAM_ARB_TIMEOUT_EN
    while (bus.gnt0 && held < 110) begin
      held++;
      step();
    end
    checks++;
    if (held !== MAX_HOLD || bus.gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_preempt: got held=%0d gnt1=%b expected %0d 1", held, bus.gnt1, MAX_HOLD);
    end
    bus.req1 = 1'b0;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_regrant: got gnt=%b expected 10", {bus.gnt0, bus.gnt1});
    end
`else
    while (bus.gnt0 && held < 100) begin
      held++;
      step();
    end
    checks++;
    if (held !== 100 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_timeout: got held=%0d gnt1=%b expected 100 0", held, bus.gnt1);
    end
    bus.req0 = 1'b0;
    step();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL hold_handover: got gnt=%b expected 01", {bus.gnt0, bus.gnt1});
    end
`endif
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_writer();
    test_readback();
    test_back_to_back();
    test_release_after_read();
    test_tie();
    test_reset_mid_burst();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
